// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared types and constants for the MCP4911-class DAC
// SPI transmitter (frame width, command nibbles, FSM state encoding).
package dac_spi_pkg;

    localparam int FRAME_W = 16;

    // Command nibble {write=0, BUF, GA, SHDN}
    localparam logic [3:0] CFG_GAIN1_ACTIVE = 4'b0011;
    localparam logic [3:0] CFG_SHDN         = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/dac_spi_tx_sck_phase_counter.sv
// sck_phase_counter: counts CLK_DIV sysclk cycles per phase and emits a
// one-cycle o_phase_end tick on the last cycle of each phase.
// Ports: i_clk, i_rst_n (sync, active-low), i_clear (hold at zero),
//        o_phase_end (last cycle of the current phase).
module sck_phase_counter #(
    parameter int CLK_DIV = 25
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_phase_end = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises a 10-bit DAC code into a 16-bit SPI write frame
// ({CFG, data, 2'b00}, MSB first) and then pulses the active-low DAC latch.
// Ports: sysclk, reset_n (sync, active-low), data_in[9:0], load (strobe);
//        dac_cs, dac_sck, dac_sdi, dac_ld, busy, overrun (all registered).
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV = 25,
    parameter logic [3:0] CFG     = CFG_GAIN1_ACTIVE
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       dac_cs,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld,
    output logic       busy,
    output logic       overrun
);

    state_t               r_state;
    state_t               w_next;
    logic [FRAME_W-1:0]   r_frame;
    logic [3:0]           r_idx;
    logic                 r_load;
    logic [9:0]           r_data;
    logic                 r_cs;
    logic                 r_sck;
    logic                 r_ld;
    logic                 r_busy;
    logic                 r_ovr;

    logic                 w_phase_end;
    logic                 w_clear;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_cs_d;
    logic                 w_sck_d;
    logic                 w_ld_d;
    logic                 w_busy_d;
    logic                 w_ovr_d;

    sck_phase_counter #(
        .CLK_DIV     (CLK_DIV)
    ) u_phase (
        .i_clk       (sysclk),
        .i_rst_n     (reset_n),
        .i_clear     (w_clear),
        .o_phase_end (w_phase_end)
    );

    // Input strobe and code are registered once; the FSM acts on the
    // registered copy so that CS falls one edge after load is sampled.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_load <= 1'b0;
            r_data <= '0;
        end else begin
            r_load <= load;
            r_data <= data_in;
        end
    end

    assign w_clear   = (r_state == IDLE);
    assign w_accept  = (r_state == IDLE) && r_load;
    assign w_bit_end = (r_state == SHIFT) && w_phase_end && r_sck;

    // State register
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (r_load) w_next = SHIFT;
            SHIFT:   if (w_bit_end && r_idx == 4'd0) w_next = LATCH;
            LATCH:   if (w_phase_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered pins
    always_comb begin
        w_cs_d   = (w_next != SHIFT);
        w_ld_d   = (w_next != LATCH);
        w_busy_d = (w_next != IDLE);
        w_sck_d  = 1'b0;
        if (r_state == SHIFT && w_next == SHIFT) begin
            w_sck_d = r_sck ^ w_phase_end;
        end
        w_ovr_d  = r_ovr | (r_load && r_state != IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_cs   <= 1'b1;
            r_sck  <= 1'b0;
            r_ld   <= 1'b1;
            r_busy <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_cs   <= w_cs_d;
            r_sck  <= w_sck_d;
            r_ld   <= w_ld_d;
            r_busy <= w_busy_d;
            r_ovr  <= w_ovr_d;
        end
    end

    // Shift register: the MSB drives SDI directly; shifting zeros in
    // leaves SDI low once the frame has been sent.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            r_frame <= '0;
            r_idx   <= 4'd0;
        end else if (w_accept) begin
            r_frame <= {CFG, r_data, 2'b00};
            r_idx   <= 4'd15;
        end else if (w_bit_end) begin
            r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
            r_idx   <= r_idx - 4'd1;
        end
    end

    assign dac_cs  = r_cs;
    assign dac_sck = r_sck;
    assign dac_sdi = r_frame[FRAME_W-1];
    assign dac_ld  = r_ld;
    assign busy    = r_busy;
    assign overrun = r_ovr;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx; one instance at
// CLK_DIV=2 for directed cases, one at CLK_DIV=25 fed by a pulse model.
module tb_dac_spi_tx;
    import dac_spi_pkg::*;

    localparam int CD0 = 2;
    localparam int CD1 = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0, load0, rst_n1, load1;
    logic [9:0] din0, din1;
    logic       cs0, sck0, sdi0, ld0, busy0, ovr0;
    logic       cs1, sck1, sdi1, ld1, busy1, ovr1;

    dac_spi_tx #(.CLK_DIV(CD0), .CFG(4'b0011)) u_dut0 (
        .sysclk (clk),   .reset_n (rst_n0), .data_in (din0),
        .load   (load0), .dac_cs  (cs0),    .dac_sck (sck0),
        .dac_sdi(sdi0),  .dac_ld  (ld0),    .busy    (busy0),
        .overrun(ovr0)
    );

    dac_spi_tx #(.CLK_DIV(CD1), .CFG(CFG_GAIN1_ACTIVE)) u_dut1 (
        .sysclk (clk),   .reset_n (rst_n1), .data_in (din1),
        .load   (load1), .dac_cs  (cs1),    .dac_sck (sck1),
        .dac_sdi(sdi1),  .dac_ld  (ld1),    .busy    (busy1),
        .overrun(ovr1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cd_of(input int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    // Scoreboard queues: expected frames per instance
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    // Monitor state
    wire [1:0] m_sck = {sck1, sck0};
    wire [1:0] m_sdi = {sdi1, sdi0};
    wire [1:0] m_cs  = {cs1, cs0};
    wire [1:0] m_ld  = {ld1, ld0};
    wire [1:0] m_rst = {rst_n1, rst_n0};

    logic [1:0]  p_sck, p_cs, p_ld;
    logic [15:0] sh[2];
    logic [15:0] m_exp;
    int nb[2], cs_cnt[2], ld_cnt[2], last_rise[2];
    int ld_pulses[2] = '{0, 0};
    int frames[2]    = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!m_rst[i]) begin
                p_sck[i] = 1'b0; p_cs[i] = 1'b1; p_ld[i] = 1'b1;
                nb[i] = 0; cs_cnt[i] = 0; ld_cnt[i] = 0;
                last_rise[i] = -1;
            end else begin
                if (!m_cs[i]) cs_cnt[i]++;
                if (!m_ld[i]) ld_cnt[i]++;
                if (m_sck[i] && !p_sck[i]) begin
                    sh[i] = {sh[i][14:0], m_sdi[i]};
                    nb[i]++;
                    if (last_rise[i] >= 0)
                        check($sformatf("sck_period%0d", i),
                              cyc - last_rise[i], 2 * cd_of(i));
                    last_rise[i] = cyc;
                end
                if (m_cs[i] && !p_cs[i]) begin
                    check($sformatf("frame_bits%0d", i), nb[i], 16);
                    check($sformatf("cs_low%0d", i), cs_cnt[i],
                          32 * cd_of(i));
                    if ((i == 0 && q0.size() == 0) ||
                        (i == 1 && q1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame%0d: got 0x%0h expected none",
                                 i, sh[i]);
                    end else begin
                        if (i == 0) m_exp = q0.pop_front();
                        else        m_exp = q1.pop_front();
                        check($sformatf("frame%0d", i), sh[i], m_exp);
                    end
                    frames[i]++;
                    nb[i] = 0; cs_cnt[i] = 0; last_rise[i] = -1;
                end
                if (m_ld[i] && !p_ld[i]) begin
                    check($sformatf("ld_low%0d", i), ld_cnt[i], cd_of(i));
                    ld_pulses[i]++;
                    ld_cnt[i] = 0;
                end
                p_sck[i] = m_sck[i];
                p_cs[i]  = m_cs[i];
                p_ld[i]  = m_ld[i];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle0(input string name);
        int k = 0;
        while (busy0 && k < 400) begin
            tick();
            k++;
        end
        if (busy0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
        end
    endtask

    task automatic send0(input logic [9:0] d, input bit expect_frame);
        din0  = d;
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        if (expect_frame) q0.push_back({4'b0011, d, 2'b00});
    endtask

    // Stand-in for the processor stage: sample pulse plus a ramp code
    function automatic logic [9:0] proc_code(input int k);
        return 10'((k * 97 + 13) & 32'h3FF);
    endfunction

    initial begin
        int k;
        int p;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        load0  = 1'b0; load1  = 1'b0;
        din0   = '0;   din1   = '0;
        repeat (3) tick();
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        tick();
        check("reset_outs0", {cs0, sck0, sdi0, ld0, busy0, ovr0}, 6'b100100);
        check("reset_outs1", {cs1, sck1, sdi1, ld1, busy1, ovr1}, 6'b100100);

        // Directed 1: 10'h2A5 -> 16'h3A94, busy falls at N+67
        send0(10'h2A5, 1'b1);
        tick();
        check("first_edge", {cs0, busy0, sck0, sdi0}, 4'b0100);
        k = 1;
        while (busy0 && k < 200) begin
            tick();
            k++;
        end
        check("busy_fall_edge", k, 67);
        repeat (3) tick();

        // Directed 2: back-to-back at the earliest acceptance edge
        send0(10'h000, 1'b1);
        repeat (66) tick();
        check("busy_before_fall", busy0, 1'b1);
        din0  = 10'h3FF;
        load0 = 1'b1;
        tick();
        load0 = 1'b0;
        q0.push_back({4'b0011, 10'h3FF, 2'b00});
        check("busy_fall_b2b", busy0, 1'b0);
        tick();
        check("b2b_started", {cs0, busy0}, 2'b01);
        wait_idle0("d2");
        check("ovr_b2b", ovr0, 1'b0);
        repeat (3) tick();

        // Directed 5: data_in churns while shifting
        send0(10'h1C3, 1'b1);
        k = 0;
        while ((busy0 || k < 2) && k < 400) begin
            din0 = 10'($urandom);
            tick();
            k++;
        end
        check("d5_done", busy0, 1'b0);
        repeat (3) tick();

        // Directed 4: reset during bit 7
        send0(10'h0AB, 1'b0);
        repeat (34) tick();
        check("d4_midframe", {cs0, busy0}, 2'b01);
        p = ld_pulses[0];
        rst_n0 = 1'b0;
        tick();
        check("d4_reset_outs", {cs0, sck0, sdi0, busy0, ld0}, 5'b10001);
        tick();
        rst_n0 = 1'b1;
        repeat (150) tick();
        check("d4_no_ld", ld_pulses[0], p);
        check("d4_idle", {busy0, ovr0}, 2'b00);

        // Directed 3: dropped load mid-frame
        send0(10'h155, 1'b1);
        repeat (10) tick();
        send0(10'h0F0, 1'b0);
        wait_idle0("d3");
        check("ovr_set", ovr0, 1'b1);
        repeat (200) tick();
        check("d3_no_second", busy0, 1'b0);
        check("ovr_sticky", ovr0, 1'b1);
        check("frames0", frames[0], 5);

        // Directed 6: CLK_DIV=25, pulse-driven frames
        for (int f = 0; f < 20; f++) begin
            din1  = proc_code(f);
            load1 = 1'b1;
            tick();
            load1 = 1'b0;
            q1.push_back({CFG_GAIN1_ACTIVE, proc_code(f), 2'b00});
            repeat (999) tick();
        end
        check("ovr1", ovr1, 1'b0);
        check("frames1", frames[1], 20);
        check("q_empty", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
